mem_wb_stage: RTL and testbench

Parametrised memory/writeback pipeline stage for the 24-bit core: accepts one instruction per handshake from EX/MEM and performs at most one data-memory access over a variable-latency req/ack port. It selects the writeback value (ALU result, load data, or old value on swap) and registers it for WB. It supersedes the fixed-width MEM/WB register and adds stall, flush, variable memory latency, atomic swap and optional forwarding outputs.

---
 rtl/mem_wb_pkg.sv | 17 +
 rtl/mem_wb_stage_if.sv | 12 +
 rtl/mem_wb_reg.sv | 32 +++
 rtl/mem_wb_stage.sv | 118 +++++++++++
 tb/tb_mem_wb_stage.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types for the memory/writeback stage: FSM state and the latched memory op.
package mem_wb_pkg;
  localparam int MEM_DATA_W     = 24;
  localparam int MEM_REG_ADDR_W = 4;

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic                      wb_en;
    logic                      rd_en;
    logic                      wr_en;
    logic                      flushed;
    logic [MEM_REG_ADDR_W-1:0] dest;
    logic [MEM_DATA_W-1:0]     alu_result;
    logic [MEM_DATA_W-1:0]     store_data;
  } mem_op_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// Variable-latency data-memory port: request held by the stage until a one-cycle ack.
interface mem_wb_stage_if #(parameter int DATA_W = 24);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_wb_reg.sv
// WB output register: loads on a retire, emits a one-cycle valid pulse, holds data otherwise.
module mem_wb_reg #(
  parameter int DATA_W     = 24,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  wb_en_nxt,
  input  logic [REG_ADDR_W-1:0] dest_nxt,
  input  logic [DATA_W-1:0]     data_nxt,
  output logic                  wb_valid,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [DATA_W-1:0]     data
);
  always_ff @(posedge clk_a or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      dest     <= '0;
      data     <= '0;
    end else begin
      wb_valid <= load;
      if (load) begin
        wb_en <= wb_en_nxt;
        dest  <= dest_nxt;
        data  <= data_nxt;
      end
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage with stall, flush, variable-latency memory and atomic swap.
// Optional forwarding outputs are built when MEM_WB_FWD_EN is defined.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int REG_ADDR_W = MEM_REG_ADDR_W
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  wb_en_in,
  input  logic                  rd_en_in,
  input  logic                  wr_en_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     store_data_in,
  mem_wb_stage_if.master        mem,
  output logic                  wb_valid,
  output logic                  wb_en_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [DATA_W-1:0]     wb_data_out
`ifdef MEM_WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  load_pending,
  output logic [REG_ADDR_W-1:0] load_dest
`endif
);
  state_t  state;
  mem_op_t op;
  logic    req_q;

  logic accept, is_mem;
  assign accept = in_valid & in_ready & ~flush;
  assign is_mem = rd_en_in | wr_en_in;

  logic                  wb_load, wb_en_nxt;
  logic [REG_ADDR_W-1:0] dest_nxt;
  logic [DATA_W-1:0]     data_nxt;

  // A flush seen on the ack cycle itself also squashes the writeback.
  always_comb begin
    wb_load   = 1'b0;
    wb_en_nxt = wb_en_in;
    dest_nxt  = dest_in;
    data_nxt  = alu_result_in;
    if (state == IDLE) begin
      wb_load = accept & ~is_mem;
    end else if (mem.ack) begin
      wb_load   = ~op.flushed & ~flush;
      wb_en_nxt = op.wb_en;
      dest_nxt  = op.dest;
      data_nxt  = op.rd_en ? mem.rdata : op.alu_result;
    end
  end

  always_ff @(posedge clk_a or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      op       <= '0;
      req_q    <= 1'b0;
      in_ready <= 1'b0;
    end else if (state == IDLE) begin
      in_ready <= 1'b1;
      if (accept && is_mem) begin
        op.wb_en      <= wb_en_in;
        op.rd_en      <= rd_en_in;
        op.wr_en      <= wr_en_in;
        op.flushed    <= 1'b0;
        op.dest       <= dest_in;
        op.alu_result <= alu_result_in;
        op.store_data <= store_data_in;
        req_q         <= 1'b1;
        in_ready      <= 1'b0;
        state         <= ACCESS;
      end
    end else begin
      // The access cannot be cancelled; a flush only marks it as not retiring.
      if (flush) op.flushed <= 1'b1;
      if (mem.ack) begin
        req_q    <= 1'b0;
        in_ready <= 1'b1;
        state    <= IDLE;
      end
    end
  end

  assign mem.req   = req_q;
  assign mem.we    = op.wr_en;
  assign mem.addr  = op.alu_result;
  assign mem.wdata = op.store_data;

  mem_wb_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_wb_reg (
    .clk_a     (clk_a),
    .rst       (rst),
    .load      (wb_load),
    .wb_en_nxt (wb_en_nxt),
    .dest_nxt  (dest_nxt),
    .data_nxt  (data_nxt),
    .wb_valid  (wb_valid),
    .wb_en     (wb_en_out),
    .dest      (dest_out),
    .data      (wb_data_out)
  );

`ifdef MEM_WB_FWD_EN
  assign fwd_valid    = wb_valid & wb_en_out;
  assign fwd_dest     = dest_out;
  assign fwd_data     = wb_data_out;
  assign load_pending = (state == ACCESS) & op.rd_en & op.wb_en & ~op.flushed;
  assign load_dest    = op.dest;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Random and directed ops against a transaction-level model of retired writebacks.
module tb_mem_wb_stage;
  logic        clk_a = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0;
  logic        wb_en_in = 1'b0, rd_en_in = 1'b0, wr_en_in = 1'b0;
  logic [3:0]  dest_in = '0;
  logic [23:0] alu_result_in = '0, store_data_in = '0;
  logic        in_ready, wb_valid, wb_en_out;
  logic [3:0]  dest_out;
  logic [23:0] wb_data_out;
`ifdef MEM_WB_FWD_EN
  logic        fwd_valid, load_pending;
  logic [3:0]  fwd_dest, load_dest;
  logic [23:0] fwd_data;
`endif

  mem_wb_stage_if #(.DATA_W(24)) mem_bus ();

  mem_wb_stage #(.DATA_W(24), .REG_ADDR_W(4)) dut (
    .clk_a(clk_a), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .wb_en_in(wb_en_in), .rd_en_in(rd_en_in), .wr_en_in(wr_en_in), .dest_in(dest_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .mem(mem_bus),
    .wb_valid(wb_valid), .wb_en_out(wb_en_out), .dest_out(dest_out), .wb_data_out(wb_data_out)
`ifdef MEM_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .load_pending(load_pending), .load_dest(load_dest)
`endif
  );

  always #5 clk_a = ~clk_a;

  int checks = 0, errors = 0;
  // last retired writeback as seen by the architectural model
  logic        m_en = 1'b0;
  logic [3:0]  m_dest = '0;
  logic [23:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic chk_wb();
    chk("wb_en_out", wb_en_out, m_en);
    chk("dest_out", dest_out, m_dest);
    chk("wb_data", wb_data_out, m_data);
  endtask

  // lat: cycles of mem_req before the ack cycle; fl_at: ACCESS cycle to flush (-1 none)
  task automatic run_op(input bit wb, input bit rd, input bit wr, input logic [3:0] d,
                        input logic [23:0] a, input logic [23:0] s, input bit fl_idle,
                        input int lat, input int fl_at, input logic [23:0] rdata);
    int  guard;
    bit  flushed;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    chk("ready_wait", guard < 50, 1);
    in_valid = 1'b1; flush = fl_idle;
    wb_en_in = wb; rd_en_in = rd; wr_en_in = wr;
    dest_in = d; alu_result_in = a; store_data_in = s;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    if (fl_idle) begin
      chk("idle_flush_valid", wb_valid, 0);
      chk("idle_flush_req", mem_bus.req, 0);
      chk_wb();
      return;
    end
    if (!(rd || wr)) begin
      m_en = wb; m_dest = d; m_data = a;
      chk("alu_valid", wb_valid, 1);
      chk("alu_req", mem_bus.req, 0);
      chk("alu_ready", in_ready, 1);
      chk_wb();
      return;
    end
    chk("req_up", mem_bus.req, 1);
    chk("req_we", mem_bus.we, wr);
    chk("req_addr", mem_bus.addr, a);
    chk("req_wdata", mem_bus.wdata, s);
    chk("req_ready", in_ready, 0);
    chk("req_valid", wb_valid, 0);
    flushed = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      if (c == fl_at) begin flush = 1'b1; flushed = 1'b1; end
      if (c == lat) begin mem_bus.ack = 1'b1; mem_bus.rdata = rdata; end
      tick();
      flush = 1'b0; mem_bus.ack = 1'b0; mem_bus.rdata = 24'($urandom);
      if (c < lat) begin
        chk("hold_req", mem_bus.req, 1);
        chk("hold_addr", mem_bus.addr, a);
        chk("hold_we", mem_bus.we, wr);
        chk("hold_wdata", mem_bus.wdata, s);
        chk("hold_ready", in_ready, 0);
        chk("hold_valid", wb_valid, 0);
      end
    end
    if (!flushed) begin
      m_en = wb; m_dest = d; m_data = rd ? rdata : a;
    end
    chk("ack_valid", wb_valid, !flushed);
    chk("ack_req", mem_bus.req, 0);
    chk("ack_ready", in_ready, 1);
    chk_wb();
  endtask

  initial begin
    mem_bus.ack = 1'b0;
    mem_bus.rdata = '0;
    // reset held with a valid bundle presented
    in_valid = 1'b1;
    repeat (3) tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", wb_valid, 0);
    chk("rst_req", mem_bus.req, 0);
    chk("rst_addr", mem_bus.addr, 0);
    chk_wb();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", wb_valid, 0);
    in_valid = 1'b0;

    run_op(1, 0, 0, 4'd1, 24'd1, 24'd0, 0, 0, -1, 24'd0);
    run_op(1, 1, 0, 4'd2, 24'd1, 24'd0, 0, 3, -1, 24'hABCDEF);
    run_op(0, 0, 1, 4'd3, 24'd2, 24'd5, 0, 2, -1, 24'h000111);
    run_op(1, 1, 1, 4'd4, 24'd2, 24'd7, 0, 1, -1, 24'd5);
    run_op(1, 1, 0, 4'd5, 24'd9, 24'd0, 0, 3, 1, 24'h123456);
    run_op(1, 1, 0, 4'd6, 24'd8, 24'd0, 0, 2, 2, 24'h654321);
    run_op(1, 0, 0, 4'd7, 24'h77, 24'd0, 1, 0, -1, 24'd0);
    // back-to-back ALU ops, no bubbles
    for (int i = 0; i < 4; i++)
      run_op(1, 0, 0, 4'(i + 8), 24'(i * 3 + 100), 24'd0, 0, 0, -1, 24'd0);

    for (int i = 0; i < 300; i++) begin
      bit wb, rd, wr, fi;
      int lat, fa;
      wb = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom);
      fi = ($urandom_range(7) == 0);
      lat = $urandom_range(4);
      fa = ($urandom_range(5) == 0) ? int'($urandom_range(lat)) : -1;
      if ($urandom_range(9) == 0) begin
        mem_bus.ack = 1'b1;
        tick();
        mem_bus.ack = 1'b0;
        chk("stray_ack_valid", wb_valid, 0);
        chk("stray_ack_req", mem_bus.req, 0);
        chk_wb();
      end
      run_op(wb, rd, wr, 4'($urandom), 24'($urandom), 24'($urandom), fi, lat, fa, 24'($urandom));
    end

    // asynchronous reset in the middle of an access
    in_valid = 1'b1; rd_en_in = 1'b1; wr_en_in = 1'b0; wb_en_in = 1'b1;
    dest_in = 4'd9; alu_result_in = 24'h42;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_arst_req", mem_bus.req, 1);
    rst = 1'b0;
    #1;
    chk("arst_req", mem_bus.req, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_addr", mem_bus.addr, 0);
    m_en = 1'b0; m_dest = '0; m_data = '0;
    chk("arst_valid", wb_valid, 0);
    chk_wb();
    #2;
    rst = 1'b1;
    mem_bus.ack = 1'b1; mem_bus.rdata = 24'h999999;
    tick();
    mem_bus.ack = 1'b0;
    chk("late_ack_valid", wb_valid, 0);
    chk("late_ack_req", mem_bus.req, 0);
    chk("late_ack_ready", in_ready, 1);
    chk_wb();
    run_op(1, 0, 0, 4'd3, 24'h33, 24'd0, 0, 0, -1, 24'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
